// File: rtl/crtc_pkg.sv
// Shared constants for the text-mode CRT controller: register map,
// control-word bit positions and raster total helpers.
package crtc_pkg;

   localparam logic [1:0] REG_CURSOR = 2'd0;
   localparam logic [1:0] REG_CTL    = 2'd1;
   localparam logic [1:0] REG_SCROLL = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int CUR_ROW_HI = 12;
   localparam int CUR_ROW_LO = 8;
   localparam int CUR_COL_HI = 6;
   localparam int CUR_COL_LO = 0;

   localparam int CTL_EN       = 15;
   localparam int CTL_START_HI = 7;
   localparam int CTL_START_LO = 4;
   localparam int CTL_END_HI   = 3;
   localparam int CTL_END_LO   = 0;

   localparam int ST_IRQ    = 15;
   localparam int ST_VBLANK = 14;

   localparam int FRAME_W = 8;

   function automatic int h_total(
      input int cols, input int cw,
      input int fp, input int sy, input int bp
   );
      return cols * cw + fp + sy + bp;
   endfunction

   function automatic int v_total(
      input int rows, input int ch,
      input int fp, input int sy, input int bp
   );
      return rows * ch + fp + sy + bp;
   endfunction

   function automatic int clog2_1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/crtc_delay.sv
// Pixel-enable gated shift register used to line sync/blank/cursor
// up with the display-memory and character-generator pipeline.
module crtc_delay #(
   parameter int           W       = 1,
   parameter int           D       = 2,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (D == 0) begin : g_direct
         logic unused_ctl;
         assign unused_ctl = ^{clk, rst_n, en};
         assign q = d;
      end else begin : g_pipe
         logic [W-1:0] stg [D];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < D; i++) stg[i] <= RST_VAL;
            end else if (en) begin
               stg[0] <= d;
               for (int i = 1; i < D; i++) stg[i] <= stg[i-1];
            end
         end

         assign q = stg[D-1];
      end
   endgenerate

endmodule

// File: rtl/txt_crtc.sv
// Parametrised text-mode CRT controller: raster timing, scrolled cell
// addressing, blink and hardware cursor. CRTC_VBLANK_IRQ_EN enables the vblank irq.
module txt_crtc
   import crtc_pkg::*;
#(
   parameter int TXT_ROWS     = 30,
   parameter int TXT_COLS     = 80,
   parameter int CHR_W        = 8,
   parameter int CHR_H        = 16,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_FP         = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 33,
   parameter int CLK_DIV      = 2,
   parameter int BLINK_FRAMES = 32,
   parameter int PIPE_DLY     = 2
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   cfg_en,
   input  logic                                   cfg_wr,
   input  logic [1:0]                             cfg_addr,
   input  logic [15:0]                            cfg_wr_data,
   output logic [15:0]                            cfg_rd_data,
   output logic                                   pix_en,
   output logic [$clog2(TXT_ROWS)-1:0]            txtrow,
   output logic [$clog2(TXT_COLS)-1:0]            txtcol,
   output logic [$clog2(CHR_H)-1:0]               chrrow,
   output logic [$clog2(CHR_W)-1:0]               chrcol,
   output logic [$clog2(TXT_ROWS*TXT_COLS)-1:0]   mem_addr,
   output logic                                   blank,
   output logic                                   hsync,
   output logic                                   vsync,
   output logic                                   blink,
   output logic                                   cursor,
   output logic                                   irq
);

   localparam int H_VIS = TXT_COLS * CHR_W;
   localparam int V_VIS = TXT_ROWS * CHR_H;
   localparam int H_TOT = h_total(TXT_COLS, CHR_W, H_FP, H_SYNC, H_BP);
   localparam int V_TOT = v_total(TXT_ROWS, CHR_H, V_FP, V_SYNC, V_BP);
   localparam int HW    = clog2_1(H_TOT);
   localparam int VW    = clog2_1(V_TOT);
   localparam int DW    = clog2_1(CLK_DIV);
   localparam int RW    = $clog2(TXT_ROWS);
   localparam int CW    = $clog2(TXT_COLS);
   localparam int YW    = $clog2(CHR_H);
   localparam int XW    = $clog2(CHR_W);
   localparam int AW    = $clog2(TXT_ROWS * TXT_COLS);

   localparam logic [RW:0]   ROWS_S = (RW+1)'(TXT_ROWS);
   localparam logic [AW-1:0] COLS_A = AW'(TXT_COLS);

   logic [DW-1:0]      div_cnt;
   logic               pix_en_r;
   logic [HW-1:0]      hcnt;
   logic [VW-1:0]      vcnt;
   logic [XW-1:0]      chrcol_c;
   logic [CW-1:0]      txtcol_c;
   logic [YW-1:0]      chrrow_c;
   logic [RW-1:0]      txtrow_c;
   logic [FRAME_W-1:0] frame_cnt;
   logic               blink_r;

   logic               h_last;
   logic               v_last;
   logic               h_vis;
   logic               v_vis;
   logic               vis;
   logic               vfp_start;

   assign h_last    = (hcnt == HW'(H_TOT - 1));
   assign v_last    = (vcnt == VW'(V_TOT - 1));
   assign h_vis     = (hcnt < HW'(H_VIS));
   assign v_vis     = (vcnt < VW'(V_VIS));
   assign vis       = h_vis & v_vis;
   assign vfp_start = pix_en_r & (hcnt == '0) & (vcnt == VW'(V_VIS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         pix_en_r <= 1'b0;
      end else begin
         if (div_cnt == DW'(CLK_DIV - 1)) div_cnt <= '0;
         else                             div_cnt <= div_cnt + 1'b1;
         pix_en_r <= (div_cnt == DW'(CLK_DIV - 1));
      end
   end

   // Cell sub-counters only run inside the visible area and wrap on
   // the last cell, so they rest at zero through the blanking intervals.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt     <= '0;
         vcnt     <= '0;
         chrcol_c <= '0;
         txtcol_c <= '0;
         chrrow_c <= '0;
         txtrow_c <= '0;
      end else if (pix_en_r) begin
         hcnt <= h_last ? '0 : hcnt + 1'b1;
         if (h_last) begin
            chrcol_c <= '0;
            txtcol_c <= '0;
         end else if (h_vis) begin
            if (chrcol_c == XW'(CHR_W - 1)) begin
               chrcol_c <= '0;
               if (txtcol_c == CW'(TXT_COLS - 1)) txtcol_c <= '0;
               else                               txtcol_c <= txtcol_c + 1'b1;
            end else begin
               chrcol_c <= chrcol_c + 1'b1;
            end
         end
         if (h_last) begin
            vcnt <= v_last ? '0 : vcnt + 1'b1;
            if (v_last) begin
               chrrow_c <= '0;
               txtrow_c <= '0;
            end else if (v_vis) begin
               if (chrrow_c == YW'(CHR_H - 1)) begin
                  chrrow_c <= '0;
                  if (txtrow_c == RW'(TXT_ROWS - 1)) txtrow_c <= '0;
                  else                               txtrow_c <= txtrow_c + 1'b1;
               end else begin
                  chrrow_c <= chrrow_c + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         blink_r   <= 1'b0;
      end else if (pix_en_r & h_last & v_last) begin
         if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
            frame_cnt <= '0;
            blink_r   <= ~blink_r;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   logic          wr_cur;
   logic          wr_ctl;
   logic          wr_scr;
   logic [4:0]    crow, crow_n, crow_q;
   logic [6:0]    ccol, ccol_n, ccol_q;
   logic          cen, cen_n, cen_q;
   logic [3:0]    cst, cst_n, cst_q;
   logic [3:0]    cend, cend_n, cend_q;
   logic [RW-1:0] scroll, scroll_n, scroll_q;

   assign wr_cur = cfg_en & cfg_wr & (cfg_addr == REG_CURSOR);
   assign wr_ctl = cfg_en & cfg_wr & (cfg_addr == REG_CTL);
   assign wr_scr = cfg_en & cfg_wr & (cfg_addr == REG_SCROLL);

   always_comb begin
      crow_n   = crow;
      ccol_n   = ccol;
      cen_n    = cen;
      cst_n    = cst;
      cend_n   = cend;
      scroll_n = scroll;
      if (wr_cur) begin
         crow_n = cfg_wr_data[CUR_ROW_HI:CUR_ROW_LO];
         ccol_n = cfg_wr_data[CUR_COL_HI:CUR_COL_LO];
      end
      if (wr_ctl) begin
         cen_n  = cfg_wr_data[CTL_EN];
         cst_n  = cfg_wr_data[CTL_START_HI:CTL_START_LO];
         cend_n = cfg_wr_data[CTL_END_HI:CTL_END_LO];
      end
      if (wr_scr) begin
         if (cfg_wr_data >= 16'(TXT_ROWS)) scroll_n = RW'(TXT_ROWS - 1);
         else                             scroll_n = RW'(cfg_wr_data);
      end
   end

   // Shadows take the post-write value so a write landing on the
   // copy cycle still reaches the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crow     <= '0;
         ccol     <= '0;
         cen      <= 1'b0;
         cst      <= '0;
         cend     <= '0;
         scroll   <= '0;
         crow_q   <= '0;
         ccol_q   <= '0;
         cen_q    <= 1'b0;
         cst_q    <= '0;
         cend_q   <= '0;
         scroll_q <= '0;
      end else begin
         crow   <= crow_n;
         ccol   <= ccol_n;
         cen    <= cen_n;
         cst    <= cst_n;
         cend   <= cend_n;
         scroll <= scroll_n;
         if (vfp_start) begin
            crow_q   <= crow_n;
            ccol_q   <= ccol_n;
            cen_q    <= cen_n;
            cst_q    <= cst_n;
            cend_q   <= cend_n;
            scroll_q <= scroll_n;
         end
      end
   end

`ifdef CRTC_VBLANK_IRQ_EN
   logic irq_r;
   logic ack;

   assign ack = cfg_en & cfg_wr & (cfg_addr == REG_STATUS)
              & cfg_wr_data[ST_IRQ];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         irq_r <= 1'b0;
      else if (vfp_start) irq_r <= 1'b1;
      else if (ack)       irq_r <= 1'b0;
   end

   assign irq = irq_r;
`else
   assign irq = 1'b0;
`endif

   logic [RW-1:0] txtrow_o;
   logic [RW:0]   row_sum;
   logic [RW-1:0] row_wrap;

   assign txtrow_o = vis ? txtrow_c : '0;
   assign row_sum  = {1'b0, txtrow_o} + {1'b0, scroll_q};
   assign row_wrap = (row_sum >= ROWS_S) ? RW'(row_sum - ROWS_S)
                                         : row_sum[RW-1:0];

   assign txtrow   = txtrow_o;
   assign txtcol   = txtcol_c;
   assign chrrow   = chrrow_c;
   assign chrcol   = chrcol_c;
   assign mem_addr = AW'(row_wrap) * COLS_A + AW'(txtcol_c);
   assign pix_en   = pix_en_r;

   logic       hs_now;
   logic       vs_now;
   logic       cur_now;
   logic [3:0] line4;
   logic [4:0] dly_q;

   assign hs_now = !((hcnt >= HW'(H_VIS + H_FP))
                  && (hcnt < HW'(H_VIS + H_FP + H_SYNC)));
   assign vs_now = !((vcnt >= VW'(V_VIS + V_FP))
                  && (vcnt < VW'(V_VIS + V_FP + V_SYNC)));
   assign line4  = 4'(chrrow_c);

   assign cur_now = cen_q
                  & (5'(txtrow_o) == crow_q)
                  & (7'(txtcol_c) == ccol_q)
                  & (cst_q <= line4) & (line4 <= cend_q)
                  & blink_r & vis;

   crtc_delay #(
      .W       (5),
      .D       (PIPE_DLY),
      .RST_VAL (5'b11100)
   ) u_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pix_en_r),
      .d     ({~vis, hs_now, vs_now, blink_r, cur_now}),
      .q     (dly_q)
   );

   assign {blank, hsync, vsync, blink, cursor} = dly_q;

   always_comb begin
      cfg_rd_data = '0;
      unique case (cfg_addr)
         REG_CURSOR: cfg_rd_data = {3'b0, crow, 1'b0, ccol};
         REG_CTL:    cfg_rd_data = {cen, 7'b0, cst, cend};
         REG_SCROLL: cfg_rd_data = 16'(scroll);
         default:    cfg_rd_data = {irq, ~v_vis, 6'b0, frame_cnt};
      endcase
   end

endmodule

// File: tb/tb_txt_crtc.sv
// Directed bench for txt_crtc on a reduced raster; a reference model
// feeds a scoreboard queue for the pipeline-delayed outputs.
module tb_txt_crtc;

   localparam int ROWS = 6;
   localparam int COLS = 5;
   localparam int CW   = 4;
   localparam int CH   = 4;
   localparam int HFP  = 2;
   localparam int HS   = 3;
   localparam int HBP  = 3;
   localparam int VFP  = 2;
   localparam int VS   = 2;
   localparam int VBP  = 2;
   localparam int CLK_DIV = 2;
   localparam int BF   = 4;
   localparam int PD   = 2;

   localparam int H_VIS = COLS * CW;
   localparam int V_VIS = ROWS * CH;
   localparam int H_TOT = H_VIS + HFP + HS + HBP;
   localparam int V_TOT = V_VIS + VFP + VS + VBP;
   localparam int FRAME = H_TOT * V_TOT;

`ifdef CRTC_VBLANK_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_en;
   logic        cfg_wr;
   logic [1:0]  cfg_addr;
   logic [15:0] cfg_wr_data;
   logic [15:0] cfg_rd_data;
   logic        pix_en;
   logic [2:0]  txtrow;
   logic [2:0]  txtcol;
   logic [1:0]  chrrow;
   logic [1:0]  chrcol;
   logic [4:0]  mem_addr;
   logic        blank;
   logic        hsync;
   logic        vsync;
   logic        blink;
   logic        cursor;
   logic        irq;

   always #5 clk = ~clk;

   txt_crtc #(
      .TXT_ROWS(ROWS), .TXT_COLS(COLS), .CHR_W(CW), .CHR_H(CH),
      .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .CLK_DIV(CLK_DIV), .BLINK_FRAMES(BF), .PIPE_DLY(PD)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_en(cfg_en), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
      .cfg_wr_data(cfg_wr_data), .cfg_rd_data(cfg_rd_data),
      .pix_en(pix_en), .txtrow(txtrow), .txtcol(txtcol),
      .chrrow(chrrow), .chrcol(chrcol), .mem_addr(mem_addr),
      .blank(blank), .hsync(hsync), .vsync(vsync),
      .blink(blink), .cursor(cursor), .irq(irq)
   );

   int passes = 0;
   int total  = 0;
   int k;
   int cur_h, cur_v, cur_f;
   int cur_hits = 0;
   int crow, ccol, cen, cst, cend, scr;
   int crow_q, ccol_q, cen_q, cst_q, cend_q, scr_q;
   int irq_m;
   int ack_p;
   logic [4:0] sb[$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s k=%0d got %0h exp %0h", tag, k, obs, exp);
   endtask

   task automatic model_reset();
      k = 0;
      crow = 0; ccol = 0; cen = 0; cst = 0; cend = 0; scr = 0;
      crow_q = 0; ccol_q = 0; cen_q = 0; cst_q = 0; cend_q = 0;
      scr_q = 0;
      irq_m = 0;
      ack_p = 0;
      sb.delete();
      for (int i = 0; i < PD; i++) sb.push_back(5'b11100);
   endtask

   task automatic step_pixel();
      int gap, ln, er, ec, ey, ex, ea, bl;
      bit vis, hsn, vsn, cu;
      logic [14:0] ecrd;
      logic [4:0] e;
      logic [4:0] o;
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (!pix_en && gap < 4 * CLK_DIV);
      chk("pix_gap", 32'(gap), 32'(CLK_DIV));
      cur_h = k % H_TOT;
      ln    = k / H_TOT;
      cur_v = ln % V_TOT;
      cur_f = ln / V_TOT;
      vis = (cur_h < H_VIS) && (cur_v < V_VIS);
      er  = vis ? cur_v / CH : 0;
      ec  = (cur_h < H_VIS) ? cur_h / CW : 0;
      ey  = (cur_v < V_VIS) ? cur_v % CH : 0;
      ex  = (cur_h < H_VIS) ? cur_h % CW : 0;
      ea  = ((er + scr_q) % ROWS) * COLS + ec;
      bl  = (cur_f / BF) % 2;
      ecrd = {3'(er), 3'(ec), 2'(ey), 2'(ex), 5'(ea)};
      chk("coords", 32'({txtrow, txtcol, chrrow, chrcol, mem_addr}),
          32'(ecrd));
      hsn = !(cur_h >= H_VIS + HFP && cur_h < H_VIS + HFP + HS);
      vsn = !(cur_v >= V_VIS + VFP && cur_v < V_VIS + VFP + VS);
      cu  = (cen_q != 0) && (er == crow_q) && (ec == ccol_q)
         && (cst_q <= ey) && (ey <= cend_q) && (bl != 0) && vis;
      e = {!vis, hsn, vsn, bl[0], cu};
      sb.push_back(e);
      o = {blank, hsync, vsync, blink, cursor};
      chk("dly_out", 32'(o), 32'(sb.pop_front()));
      chk("irq", 32'(irq), 32'(irq_m));
      if (cursor === 1'b1) cur_hits++;
   endtask

   task automatic commit();
      if (cur_h == 0 && cur_v == V_VIS) begin
         crow_q = crow; ccol_q = ccol; cen_q = cen;
         cst_q = cst; cend_q = cend; scr_q = scr;
         if (IRQ_EN) irq_m = 1;
      end else if (ack_p != 0) begin
         irq_m = 0;
      end
      ack_p = 0;
      k++;
   endtask

   task automatic run_pixels(input int n);
      for (int i = 0; i < n; i++) begin
         step_pixel();
         commit();
      end
   endtask

   task automatic run_to_k(input int t);
      run_pixels(t - k);
   endtask

   task automatic run_to(input int th, input int tv);
      int n;
      n = 0;
      forever begin
         step_pixel();
         if (cur_h == th && cur_v == tv) break;
         if (n > 2 * FRAME) begin
            total++;
            $error("FAIL run_to timeout got %0d,%0d exp %0d,%0d",
                   cur_h, cur_v, th, tv);
            break;
         end
         commit();
         n++;
      end
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
      cfg_en = 1'b1;
      cfg_wr = 1'b1;
      cfg_addr = a;
      cfg_wr_data = d;
      @(posedge clk);
      #1;
      cfg_en = 1'b0;
      cfg_wr = 1'b0;
      unique case (a)
         2'd0: begin crow = int'(d[12:8]); ccol = int'(d[6:0]); end
         2'd1: begin
            cen = int'(d[15]); cst = int'(d[7:4]); cend = int'(d[3:0]);
         end
         2'd2: scr = (d >= 16'(ROWS)) ? ROWS - 1 : int'(d);
         default: if (d[15]) ack_p = 1;
      endcase
   endtask

   task automatic cfg_read(input logic [1:0] a, input string tag);
      int exp;
      cfg_addr = a;
      cfg_wr = 1'b0;
      #1;
      unique case (a)
         2'd0: exp = (crow << 8) | ccol;
         2'd1: exp = (cen << 15) | (cst << 4) | cend;
         2'd2: exp = scr;
         default: exp = (irq_m << 15) | (int'(cur_v >= V_VIS) << 14)
                      | (cur_f % BF);
      endcase
      chk(tag, 32'(cfg_rd_data), 32'(exp));
   endtask

   task automatic chk_reset();
      chk("rst_pix_en", 32'(pix_en), 32'd0);
      chk("rst_dly", 32'({blank, hsync, vsync, blink, cursor}),
          32'(5'b11100));
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_coords",
          32'({txtrow, txtcol, chrrow, chrcol, mem_addr}), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cfg_addr = 2'(i);
         #1;
         chk("rst_reg", 32'(cfg_rd_data), 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_en = 1'b0;
      cfg_wr = 1'b0;
      cfg_addr = 2'd0;
      cfg_wr_data = 16'd0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk_reset();
      @(negedge clk);
      rst_n = 1'b1;

      step_pixel(); cfg_write(2'd0, 16'h0302); commit();
      step_pixel(); cfg_write(2'd1, 16'h8023); commit();
      step_pixel(); cfg_write(2'd2, 16'd1);    commit();
      step_pixel();
      cfg_read(2'd0, "rd_cursor");
      cfg_read(2'd1, "rd_ctl");
      cfg_read(2'd2, "rd_scroll");
      cfg_write(2'd2, 16'd9);
      commit();
      step_pixel(); cfg_read(2'd2, "rd_scroll_clip"); commit();

      run_to(0, V_VIS);
      cfg_read(2'd3, "rd_status_pre");
      commit();
      step_pixel();
      cfg_read(2'd3, "rd_status_irq");
      cfg_write(2'd3, 16'h8000);
      commit();
      step_pixel(); cfg_read(2'd3, "rd_status_ack"); commit();

      run_to_k(FRAME + 10 * H_TOT + 3);
      step_pixel(); cfg_write(2'd2, 16'd2); commit();
      run_to(0, V_VIS); cfg_write(2'd2, 16'd3); commit();

      run_to_k(2 * FRAME + 5);
      run_to(0, V_VIS); cfg_write(2'd3, 16'h8000); commit();
      step_pixel(); cfg_read(2'd3, "rd_status_set_ack"); commit();

      run_to_k(5 * FRAME + 100);
      step_pixel(); cfg_write(2'd1, 16'h8032); commit();

      run_to_k(7 * FRAME + 300);
      step_pixel();
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset();
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run_pixels(3 * H_TOT);

      chk("cursor_hits", 32'(cur_hits), 32'd16);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
